// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall, flush and bubble accounting.
// Bubbles are zeroed control/index fields so forwarding never matches them.
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            register_write_d,
  input  logic            memory_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic            alu_src_d,
  input  logic [1:0]      result_src_d,
  input  logic [2:0]      alu_control_d,
  output logic            valid_ex,
  output logic [XLEN-1:0] pc_ex,
  output logic [XLEN-1:0] pc_plus4_ex,
  output logic [XLEN-1:0] rd1_ex,
  output logic [XLEN-1:0] rd2_ex,
  output logic [XLEN-1:0] imm_ext_ex,
  output logic [4:0]      rs1_ex,
  output logic [4:0]      rs2_ex,
  output logic [4:0]      rd_ex,
  output logic            register_write_ex,
  output logic            memory_write_ex,
  output logic            jump_ex,
  output logic            branch_ex,
  output logic            alu_src_ex,
  output logic [1:0]      result_src_ex,
  output logic [2:0]      alu_control_ex,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_wr;
    logic            mem_wr;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      res_src;
    logic [2:0]      alu_ctl;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            bubble;

  // Next-state: flush beats stall beats load; invalid loads become bubbles.
  always_comb begin
    ex_d   = ex_q;
    bubble = 1'b0;
    if (flush_e) begin
      ex_d   = '0;
      bubble = 1'b1;
    end else if (!stall_e) begin
      ex_d.valid    = valid_d;
      ex_d.pc       = pc_d;
      ex_d.pc_plus4 = pc_plus4_d;
      ex_d.rd1      = rd1_d;
      ex_d.rd2      = rd2_d;
      ex_d.imm      = imm_ext_d;
      ex_d.rs1      = rs1_d;
      ex_d.rs2      = rs2_d;
      ex_d.rd       = rd_d;
      ex_d.reg_wr   = register_write_d;
      ex_d.mem_wr   = memory_write_d;
      ex_d.jump     = jump_d;
      ex_d.branch   = branch_d;
      ex_d.alu_src  = alu_src_d;
      ex_d.res_src  = result_src_d;
      ex_d.alu_ctl  = alu_control_d;
      if (!valid_d) begin
        ex_d.rs1     = '0;
        ex_d.rs2     = '0;
        ex_d.rd      = '0;
        ex_d.reg_wr  = 1'b0;
        ex_d.mem_wr  = 1'b0;
        ex_d.jump    = 1'b0;
        ex_d.branch  = 1'b0;
        ex_d.alu_src = 1'b0;
        ex_d.res_src = '0;
        ex_d.alu_ctl = '0;
        bubble       = 1'b1;
      end
    end
    cnt_d = cnt_q;
    if (bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage register and saturating bubble counter, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_ex          = ex_q.valid;
  assign pc_ex             = ex_q.pc;
  assign pc_plus4_ex       = ex_q.pc_plus4;
  assign rd1_ex            = ex_q.rd1;
  assign rd2_ex            = ex_q.rd2;
  assign imm_ext_ex        = ex_q.imm;
  assign rs1_ex            = ex_q.rs1;
  assign rs2_ex            = ex_q.rs2;
  assign rd_ex             = ex_q.rd;
  assign register_write_ex = ex_q.reg_wr;
  assign memory_write_ex   = ex_q.mem_wr;
  assign jump_ex           = ex_q.jump;
  assign branch_ex         = ex_q.branch;
  assign alu_src_ex        = ex_q.alu_src;
  assign result_src_ex     = ex_q.res_src;
  assign alu_control_ex    = ex_q.alu_ctl;
  assign bubble_count      = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: vector table through a scoreboard,
// plus a saturation sequence on a narrow-counter instance.
module tb_id_ex_pipeline_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall_e, flush_e, valid_d;
  logic [31:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        register_write_d, memory_write_d;
  logic        jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;

  logic        valid_ex;
  logic [31:0] pc_ex, pc_plus4_ex, rd1_ex, rd2_ex, imm_ext_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic        register_write_ex, memory_write_ex;
  logic        jump_ex, branch_ex, alu_src_ex;
  logic [1:0]  result_src_ex;
  logic [2:0]  alu_control_ex;
  logic [15:0] bubble_count;

  logic        s_valid;
  logic [31:0] s_pc, s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_rw, s_mw, s_j, s_b, s_as;
  logic [1:0]  s_rs;
  logic [2:0]  s_ac;
  logic [3:0]  s_cnt;

  id_ex_pipeline_reg u_dut (
    .clk(clk), .reset(reset),
    .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .register_write_d(register_write_d),
    .memory_write_d(memory_write_d),
    .jump_d(jump_d), .branch_d(branch_d),
    .alu_src_d(alu_src_d),
    .result_src_d(result_src_d),
    .alu_control_d(alu_control_d),
    .valid_ex(valid_ex),
    .pc_ex(pc_ex), .pc_plus4_ex(pc_plus4_ex),
    .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
    .imm_ext_ex(imm_ext_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .register_write_ex(register_write_ex),
    .memory_write_ex(memory_write_ex),
    .jump_ex(jump_ex), .branch_ex(branch_ex),
    .alu_src_ex(alu_src_ex),
    .result_src_ex(result_src_ex),
    .alu_control_ex(alu_control_ex),
    .bubble_count(bubble_count)
  );

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .register_write_d(register_write_d),
    .memory_write_d(memory_write_d),
    .jump_d(jump_d), .branch_d(branch_d),
    .alu_src_d(alu_src_d),
    .result_src_d(result_src_d),
    .alu_control_d(alu_control_d),
    .valid_ex(s_valid),
    .pc_ex(s_pc), .pc_plus4_ex(s_pc4),
    .rd1_ex(s_rd1), .rd2_ex(s_rd2),
    .imm_ext_ex(s_imm),
    .rs1_ex(s_rs1), .rs2_ex(s_rs2), .rd_ex(s_rd),
    .register_write_ex(s_rw),
    .memory_write_ex(s_mw),
    .jump_ex(s_j), .branch_ex(s_b),
    .alu_src_ex(s_as),
    .result_src_ex(s_rs),
    .alu_control_ex(s_ac),
    .bubble_count(s_cnt)
  );

  typedef struct {
    logic        rst, st, fl, v;
    logic [31:0] pc, rd1;
    logic [4:0]  rd, rs1;
    logic        rw, dc;
    logic [31:0] e_pc, e_rd1;
    logic [4:0]  e_rd, e_rs1;
    logic        e_rw, e_v;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[16];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    logic rst, logic st, logic fl, logic v,
    logic [31:0] pc, logic [4:0] rd,
    logic [4:0] rs1, logic rw,
    logic [31:0] rd1, logic dc,
    logic [31:0] epc, logic [4:0] erd,
    logic [4:0] ers1, logic erw, logic ev,
    logic [31:0] erd1, logic [15:0] ecnt);
    vec_t t;
    t.rst = rst; t.st = st; t.fl = fl; t.v = v;
    t.pc = pc; t.rd = rd; t.rs1 = rs1;
    t.rw = rw; t.rd1 = rd1; t.dc = dc;
    t.e_pc = epc; t.e_rd = erd; t.e_rs1 = ers1;
    t.e_rw = erw; t.e_v = ev; t.e_rd1 = erd1;
    t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               n, a, e, $time);
    end
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    reset            = t.rst;
    stall_e          = t.st;
    flush_e          = t.fl;
    valid_d          = t.v;
    pc_d             = t.pc;
    pc_plus4_d       = t.pc + 32'd4;
    rd1_d            = t.rd1;
    rd2_d            = ~t.rd1;
    imm_ext_d        = t.pc ^ 32'h0F0F;
    rs1_d            = t.rs1;
    rs2_d            = t.rs1 + 5'd8;
    rd_d             = t.rd;
    register_write_d = t.rw;
    memory_write_d   = 1'b1;
    jump_d           = 1'b0;
    branch_d         = 1'b1;
    alu_src_d        = 1'b1;
    result_src_d     = 2'd2;
    alu_control_d    = 3'd5;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid", 32'(valid_ex), 32'(e.e_v));
    chk("rd", 32'(rd_ex), 32'(e.e_rd));
    chk("rs1", 32'(rs1_ex), 32'(e.e_rs1));
    chk("regwr", 32'(register_write_ex), 32'(e.e_rw));
    chk("bcnt", 32'(bubble_count), 32'(e.e_cnt));
    if (e.e_v) begin
      chk("rs2", 32'(rs2_ex), 32'(5'(e.e_rs1 + 5'd8)));
      chk("memwr", 32'(memory_write_ex), 32'd1);
      chk("jump", 32'(jump_ex), 32'd0);
      chk("branch", 32'(branch_ex), 32'd1);
      chk("alusrc", 32'(alu_src_ex), 32'd1);
      chk("ressrc", 32'(result_src_ex), 32'd2);
      chk("aluctl", 32'(alu_control_ex), 32'd5);
    end else begin
      chk("rs2_z", 32'(rs2_ex), 32'd0);
      chk("memwr_z", 32'(memory_write_ex), 32'd0);
      chk("jump_z", 32'(jump_ex), 32'd0);
      chk("branch_z", 32'(branch_ex), 32'd0);
      chk("alusrc_z", 32'(alu_src_ex), 32'd0);
      chk("ressrc_z", 32'(result_src_ex), 32'd0);
      chk("aluctl_z", 32'(alu_control_ex), 32'd0);
    end
    if (e.dc) begin
      if (e.e_v) begin
        chk("pc", pc_ex, e.e_pc);
        chk("pc4", pc_plus4_ex, e.e_pc + 32'd4);
        chk("rd1", rd1_ex, e.e_rd1);
        chk("rd2", rd2_ex, ~e.e_rd1);
        chk("imm", imm_ext_ex, e.e_pc ^ 32'h0F0F);
      end else begin
        chk("pc_z", pc_ex, 32'd0);
        chk("pc4_z", pc_plus4_ex, 32'd0);
        chk("rd1_z", rd1_ex, 32'd0);
        chk("rd2_z", rd2_ex, 32'd0);
        chk("imm_z", imm_ext_ex, 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    valid_d = 1'b0;
    pc_d = '0; pc_plus4_d = '0; rd1_d = '0;
    rd2_d = '0; imm_ext_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
    register_write_d = 1'b0; memory_write_d = 1'b0;
    jump_d = 1'b0; branch_d = 1'b0; alu_src_d = 1'b0;
    result_src_d = '0; alu_control_d = '0;

    vt[0]  = mk(1,0,0,1,'h50,1,1,1,'h1,1,
                0,0,0,0,0,0,0);
    vt[1]  = mk(0,0,0,1,'h100,5,3,1,'h11,1,
                'h100,5,3,1,1,'h11,0);
    vt[2]  = mk(0,0,0,1,'h200,6,1,0,'h22,1,
                'h200,6,1,0,1,'h22,0);
    vt[3]  = mk(0,1,0,1,'h204,7,2,1,'h23,1,
                'h200,6,1,0,1,'h22,0);
    vt[4]  = mk(0,1,0,1,'h208,7,2,1,'h24,1,
                'h200,6,1,0,1,'h22,0);
    vt[5]  = mk(0,1,0,1,'h20C,7,2,1,'h25,1,
                'h200,6,1,0,1,'h22,0);
    vt[6]  = mk(0,0,0,1,'h20C,7,2,1,'h33,1,
                'h20C,7,2,1,1,'h33,0);
    vt[7]  = mk(0,1,1,1,'h300,7,2,1,'h44,1,
                0,0,0,0,0,0,1);
    vt[8]  = mk(0,0,0,0,'h400,9,6,1,'hDEADBEEF,0,
                'h400,0,0,0,0,'hDEADBEEF,2);
    vt[9]  = mk(0,0,0,1,'h500,10,4,1,'h55,1,
                'h500,10,4,1,1,'h55,2);
    vt[10] = mk(0,1,0,1,'h504,11,5,0,'h56,1,
                'h500,10,4,1,1,'h55,2);
    vt[11] = mk(1,1,0,1,'h508,12,6,1,'h57,1,
                0,0,0,0,0,0,0);
    vt[12] = mk(0,0,0,1,'h600,11,5,1,'h66,1,
                'h600,11,5,1,1,'h66,0);
    vt[13] = mk(0,0,1,0,'h604,3,3,1,'h67,1,
                0,0,0,0,0,0,1);
    vt[14] = mk(0,1,0,1,'h608,3,3,1,'h77,1,
                0,0,0,0,0,0,1);
    vt[15] = mk(0,1,0,0,'h60C,3,3,1,'h78,1,
                0,0,0,0,0,0,1);

    for (int i = 0; i < 16; i++) apply(vt[i]);

    // saturation on the 4-bit counter instance
    reset = 1'b1; flush_e = 1'b0; stall_e = 1'b0;
    @(posedge clk); #1;
    chk("sat_rst", 32'(s_cnt), 32'd0);
    reset = 1'b0; flush_e = 1'b1; valid_d = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("sat_cnt", 32'(s_cnt),
          (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk("wide_cnt", 32'(bubble_count), 32'(i + 1));
      chk("sat_valid", 32'(s_valid), 32'd0);
    end
    stall_e = 1'b1;
    @(posedge clk); #1;
    chk("sat_hold", 32'(s_cnt), 32'd15);
    chk("wide_fs", 32'(bubble_count), 32'd21);
    flush_e = 1'b0; stall_e = 1'b0; valid_d = 1'b0;
    @(posedge clk); #1;
    chk("sat_bub", 32'(s_cnt), 32'd15);
    chk("wide_bub", 32'(bubble_count), 32'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
